// File: rtl/alu_multicycle_exec_if.sv
// Request/result bundle between the decode stage, the execution unit and write-back.
interface alu_multicycle_exec_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
);
    logic                   start_i;
    logic                   ready_o;
    logic [3:0]             alu_operation_i;
    logic [DATA_WIDTH-1:0]  a_i;
    logic [DATA_WIDTH-1:0]  b_i;
    logic [SHAMT_WIDTH-1:0] shamt_i;
    logic [DATA_WIDTH-1:0]  result_o;
    logic                   zero_o;
    logic                   illegal_o;
    logic                   valid_o;

    // Requester side: issues operations, observes completion.
    modport master (
        output start_i, alu_operation_i, a_i, b_i, shamt_i,
        input  ready_o, result_o, zero_o, illegal_o, valid_o
    );

    // Execution unit side.
    modport slave (
        input  start_i, alu_operation_i, a_i, b_i, shamt_i,
        output ready_o, result_o, zero_o, illegal_o, valid_o
    );
endinterface

// File: rtl/alu_multicycle_exec.sv
// Multi-cycle ALU: single-cycle logic/arithmetic, bit-serial shifts, one-cycle valid pulse.
module alu_multicycle_exec #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_multicycle_exec_if.slave bus
);
    localparam int unsigned HALF = DATA_WIDTH / 2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_ANDI = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   left_q, left_d;

    logic [DATA_WIDTH-1:0]  alu_res_c;
    logic                   alu_ill_c;
    logic                   is_shift_c;
    logic [DATA_WIDTH-1:0]  shifted_c;

    // Single-cycle result for the op presented at accept; a zero-length shift yields b.
    always_comb begin
        alu_res_c  = '0;
        alu_ill_c  = 1'b0;
        is_shift_c = 1'b0;
        case (bus.alu_operation_i)
            OP_ADD, OP_LW, OP_SW: alu_res_c = bus.a_i + bus.b_i;
            OP_SUB:               alu_res_c = bus.a_i - bus.b_i;
            OP_OR, OP_ORI:        alu_res_c = bus.a_i | bus.b_i;
            OP_ANDI, OP_AND:      alu_res_c = bus.a_i & bus.b_i;
            OP_NOR:               alu_res_c = ~(bus.a_i | bus.b_i);
            OP_LUI:               alu_res_c = {bus.b_i[HALF-1:0], {HALF{1'b0}}};
            OP_SRL, OP_SLL: begin
                alu_res_c  = bus.b_i;
                is_shift_c = 1'b1;
            end
            default: begin
                alu_res_c = '0;
                alu_ill_c = 1'b1;
            end
        endcase
        shifted_c = left_q ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                           : {1'b0, shreg_q[DATA_WIDTH-1:1]};
    end

    // Next-state and datapath update; result/flags change only on completion.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (is_shift_c && (bus.shamt_i != '0)) begin
                        state_d = SHIFT;
                        shreg_d = bus.b_i;
                        cnt_d   = bus.shamt_i;
                        left_d  = (bus.alu_operation_i == OP_SLL);
                    end else begin
                        state_d   = DONE;
                        result_d  = alu_res_c;
                        zero_d    = (alu_res_c == '0);
                        illegal_d = alu_ill_c;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shifted_c;
                cnt_d   = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    state_d   = DONE;
                    result_d  = shifted_c;
                    zero_d    = (shifted_c == '0);
                    illegal_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
        end
    end

    assign bus.ready_o   = (state_q == IDLE);
    assign bus.valid_o   = (state_q == DONE);
    assign bus.result_o  = result_q;
    assign bus.zero_o    = zero_q;
    assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Scoreboard bench for alu_multicycle_exec.
module tb_alu_multicycle_exec;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          acc;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_valid = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_multicycle_exec_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus ();

    alu_multicycle_exec #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Count a comparison and report any mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference behaviour of the op set.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0, 4'd8, 4'd9: return a + b;
            4'd1:             return a - b;
            4'd2, 4'd3:       return a | b;
            4'd7, 4'd13:      return a & b;
            4'd12:            return ~(a | b);
            4'd6:             return {b[15:0], 16'h0000};
            4'd4:             return b >> sh;
            4'd5:             return b << sh;
            default:          return 32'h0;
        endcase
    endfunction

    function automatic bit is_ill(input logic [3:0] op);
        return (op == 4'd10) || (op == 4'd11) || (op == 4'd14) || (op == 4'd15);
    endfunction

    // Wait for ready, present an op, push its expectation at the accepting edge.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit hold);
        exp_t e;
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.ready_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.ready_o) chk({tag, "_ready_timeout"}, 32'(bus.ready_o), 32'd1);
        bus.start_i = 1'b1;
        bus.alu_operation_i = op;
        bus.a_i = a;
        bus.b_i = b;
        bus.shamt_i = sh;
        @(posedge clk);
        #1;
        e.res  = model(op, a, b, sh);
        e.ill  = is_ill(op);
        e.zero = (e.res == 32'h0);
        e.lat  = (op == 4'd4 || op == 4'd5) ? int'(sh) + 1 : 1;
        e.acc  = cyc;
        e.tag  = tag;
        sb.push_back(e);
        if (!hold) bus.start_i = 1'b0;
    endtask

    // Let all pushed expectations drain, bounded.
    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Result monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.valid_o) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_result"}, bus.result_o, e.res);
                chk({e.tag, "_zero"}, 32'(bus.zero_o), 32'(e.zero));
                chk({e.tag, "_illegal"}, 32'(bus.illegal_o), 32'(e.ill));
                chk({e.tag, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int v0;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;

        bus.start_i = 1'b0;
        bus.alu_operation_i = 4'd0;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.shamt_i = '0;
        reset = 1'b1;
        #12;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'h0);
        chk("rst_zero", 32'(bus.zero_o), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD wrap: valid next cycle, ready back the cycle after
        issue("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
        @(negedge clk);
        chk("add_valid", 32'(bus.valid_o), 32'd1);
        chk("add_ready_busy", 32'(bus.ready_o), 32'd0);
        @(negedge clk);
        chk("add_ready_back", 32'(bus.ready_o), 32'd1);
        chk("add_valid_pulse", 32'(bus.valid_o), 32'd0);
        drain();

        issue("sub", 4'd1, 32'd5, 32'd7, 5'd3, 1'b0);
        issue("nor", 4'd12, 32'h0, 32'h0, 5'd0, 1'b0);
        issue("lui", 4'd6, 32'hDEAD_0000, 32'h0000_1234, 5'd0, 1'b0);
        drain();

        // SRL 31 while start stays asserted with another op during the busy window
        v0 = n_valid;
        issue("srl31", 4'd4, 32'h0, 32'h8000_0000, 5'd31, 1'b0);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.alu_operation_i = 4'd0;
        bus.a_i = 32'd1;
        bus.b_i = 32'd1;
        repeat (20) @(negedge clk);
        bus.start_i = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        chk("srl_busy_ignored", 32'(n_valid - v0), 32'd1);

        issue("sll0", 4'd5, 32'h0, 32'hA5A5_A5A5, 5'd0, 1'b0);
        issue("illegal", 4'd15, 32'd3, 32'd4, 5'd0, 1'b0);
        issue("or_after_ill", 4'd2, 32'hF0, 32'h0F, 5'd0, 1'b0);
        drain();
        repeat (4) @(negedge clk);
        chk("result_hold", bus.result_o, 32'hFF);

        // Async reset in the middle of a long SLL
        v0 = n_valid;
        issue("sll20_abort", 4'd5, 32'h0, 32'h0000_0003, 5'd20, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ready", 32'(bus.ready_o), 32'd1);
        chk("arst_valid", 32'(bus.valid_o), 32'd0);
        chk("arst_result", bus.result_o, 32'h0);
        chk("arst_zero", 32'(bus.zero_o), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("arst_no_valid", 32'(n_valid - v0), 32'd0);

        // Back-to-back with start held high throughout
        v0 = n_valid;
        issue("b2b_add", 4'd0, 32'd10, 32'd20, 5'd0, 1'b1);
        issue("b2b_sll", 4'd5, 32'h0, 32'h0000_0003, 5'd2, 1'b1);
        issue("b2b_and", 4'd13, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 1'b0);
        drain();
        chk("b2b_count", 32'(n_valid - v0), 32'd3);

        // Random mix, shifts kept short
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            sh = (op == 4'd4 || op == 4'd5) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            issue("rand", op, a, b, sh, 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
